// File: rtl/battleship_pkg.sv
// Shared types and constants for the battleship player-board datapath.
package battleship_pkg;

  localparam int unsigned NCELLS = 16;
  localparam int unsigned CurW   = $clog2(NCELLS);

  typedef logic [NCELLS-1:0] board_t;

  typedef enum logic [1:0] {
    StIdle,
    StPick,
    StHold,
    StDone
  } state_e;

  function automatic board_t onehot(input logic [CurW-1:0] idx);
    return board_t'(1) << idx;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: two-flop synchronizer, stability counter and
// registered rising-edge detect giving one pulse per accepted press.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic clr_ni,
  input  logic raw_i,
  output logic pulse_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_d, level_q;
  logic            pulse_d, pulse_q;
  logic [CntW-1:0] cnt_d, cnt_q;

  // A level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    level_d = level_q;
    pulse_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/attack_entry.sv
// Button-driven attack selection: cursor, single-cell pick, and handshaked
// offer of the cumulative attack word to the downstream attack register.
module attack_entry
  import battleship_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic            clk_i,
  input  logic            clr_ni,
  input  logic            new_game_i,
  input  logic            en_i,
  input  logic            btn_move_raw_i,
  input  logic            btn_sel_raw_i,
  input  logic            btn_fire_raw_i,
  input  logic            atk_ready_i,
  output logic [CurW-1:0] cursor_o,
  output board_t          disp_word_o,
  output board_t          atk_word_o,
  output logic            atk_valid_o,
  output logic            err_o,
  output logic            full_o
);

  logic move_pulse, sel_pulse, fire_pulse;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_move (
    .clk_i  (clk_i),
    .clr_ni (clr_ni),
    .raw_i  (btn_move_raw_i),
    .pulse_o(move_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sel (
    .clk_i  (clk_i),
    .clr_ni (clr_ni),
    .raw_i  (btn_sel_raw_i),
    .pulse_o(sel_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_fire (
    .clk_i  (clk_i),
    .clr_ni (clr_ni),
    .raw_i  (btn_fire_raw_i),
    .pulse_o(fire_pulse)
  );

  state_e          state_d, state_q;
  logic [CurW-1:0] cursor_d, cursor_q;
  board_t          pending_d, pending_q;
  board_t          hist_d, hist_q;
  board_t          word_d, word_q;
  logic            valid_d, valid_q;
  logic            err_d, err_q;

  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    pending_d = pending_q;
    hist_d    = hist_q;
    word_d    = word_q;
    valid_d   = valid_q;
    err_d     = 1'b0;

    if (new_game_i) begin
      state_d   = StIdle;
      cursor_d  = '0;
      pending_d = '0;
      hist_d    = '0;
      word_d    = '0;
      valid_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en_i) state_d = StPick;
        end
        StPick: begin
          // Losing the turn abandons any pick; otherwise fire > sel > move.
          if (!en_i) begin
            pending_d = '0;
            state_d   = StIdle;
          end else if (fire_pulse) begin
            if (pending_q == '0) begin
              err_d = 1'b1;
            end else begin
              word_d  = hist_q | pending_q;
              valid_d = 1'b1;
              state_d = StHold;
            end
          end else if (sel_pulse) begin
            if (hist_q[cursor_q]) begin
              err_d = 1'b1;
            end else if (pending_q == onehot(cursor_q)) begin
              pending_d = '0;
            end else begin
              pending_d = onehot(cursor_q);
            end
          end else if (move_pulse) begin
            cursor_d = cursor_q + 1'b1;
          end
        end
        StHold: begin
          if (atk_ready_i) begin
            hist_d    = word_q;
            pending_d = '0;
            valid_d   = 1'b0;
            state_d   = StDone;
          end
        end
        StDone: begin
          if (!en_i) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      state_q   <= StIdle;
      cursor_q  <= '0;
      pending_q <= '0;
      hist_q    <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      pending_q <= pending_d;
      hist_q    <= hist_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign cursor_o    = cursor_q;
  assign disp_word_o = hist_q | pending_q;
  assign atk_word_o  = word_q;
  assign atk_valid_o = valid_q;
  assign err_o       = err_q;
  assign full_o      = &hist_q;

endmodule

// File: tb/tb_attack_entry.sv
// Scoreboard bench for attack_entry: stimulus queues each expected change of
// the output vector, a negedge monitor pops and compares on every change.
module tb_attack_entry;

  localparam int unsigned Deb = 4;

  logic        clk_i = 1'b0;
  logic        clr_ni = 1'b0;
  logic        new_game_i = 1'b0;
  logic        en_i = 1'b0;
  logic        mv_raw = 1'b0;
  logic        sel_raw = 1'b0;
  logic        fire_raw = 1'b0;
  logic        atk_ready_i = 1'b0;
  logic [3:0]  cursor_o;
  logic [15:0] disp_word_o;
  logic [15:0] atk_word_o;
  logic        atk_valid_o;
  logic        err_o;
  logic        full_o;

  attack_entry #(.DEBOUNCE_CYCLES(Deb)) dut (
    .clk_i         (clk_i),
    .clr_ni        (clr_ni),
    .new_game_i    (new_game_i),
    .en_i          (en_i),
    .btn_move_raw_i(mv_raw),
    .btn_sel_raw_i (sel_raw),
    .btn_fire_raw_i(fire_raw),
    .atk_ready_i   (atk_ready_i),
    .cursor_o      (cursor_o),
    .disp_word_o   (disp_word_o),
    .atk_word_o    (atk_word_o),
    .atk_valid_o   (atk_valid_o),
    .err_o         (err_o),
    .full_o        (full_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0]  cur;
    logic [15:0] disp;
    logic [15:0] word;
    logic        valid;
    logic        err;
    logic        full;
  } obs_t;

  obs_t        exp_q[$];
  obs_t        prev_obs = '0;
  int          n_checks = 0;
  int          n_fails = 0;
  int          n_events = 0;
  logic [3:0]  m_cur = '0;
  logic [15:0] m_hist = '0;
  logic [15:0] m_word = '0;
  logic [15:0] m_pend = '0;

  always @(negedge clk_i) begin
    obs_t now_obs;
    obs_t want;
    now_obs = {cursor_o, disp_word_o, atk_word_o, atk_valid_o, err_o, full_o};
    if (now_obs != prev_obs) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL event%0d unexpected change: got %h, required unchanged %h",
                 n_events, now_obs, prev_obs);
      end else begin
        want = exp_q.pop_front();
        if (now_obs !== want) begin
          n_fails++;
          $display("FAIL event%0d {cur,disp,word,valid,err,full}: got %h, required %h",
                   n_events, now_obs, want);
        end
      end
      n_events++;
    end
    prev_obs = now_obs;
  end

  task automatic push_exp(input logic [3:0] cur, input logic [15:0] disp,
                          input logic [15:0] word, input logic valid, input logic err,
                          input logic full);
    obs_t e;
    e = {cur, disp, word, valid, err, full};
    exp_q.push_back(e);
  endtask

  task automatic push_model(input logic valid, input logic err);
    push_exp(m_cur, m_hist | m_pend, m_word, valid, err, &m_hist);
  endtask

  task automatic push_err();
    push_model(1'b0, 1'b1);
    push_model(1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // 0 = move, 1 = sel, 2 = fire; held well past the debounce window both ways
  task automatic press(input int which);
    case (which)
      0: mv_raw = 1'b1;
      1: sel_raw = 1'b1;
      default: fire_raw = 1'b1;
    endcase
    tick(8);
    mv_raw = 1'b0;
    sel_raw = 1'b0;
    fire_raw = 1'b0;
    tick(8);
  endtask

  task automatic move_to(input logic [3:0] target);
    while (m_cur != target) begin
      m_cur = m_cur + 4'd1;
      push_model(1'b0, 1'b0);
      press(0);
    end
  endtask

  task automatic pick_fire(input logic [3:0] target);
    move_to(target);
    m_pend = 16'd1 << target;
    push_model(1'b0, 1'b0);
    press(1);
    m_word = m_hist | m_pend;
    push_model(1'b1, 1'b0);
    press(2);
    check("hold_valid", {31'd0, atk_valid_o}, 32'd1);
    check("hold_word", {16'd0, atk_word_o}, {16'd0, m_word});
  endtask

  task automatic accept();
    m_hist = m_word;
    m_pend = '0;
    push_model(1'b0, 1'b0);
    atk_ready_i = 1'b1;
    tick(1);
    atk_ready_i = 1'b0;
    check("accept_valid_low", {31'd0, atk_valid_o}, 32'd0);
  endtask

  task automatic new_turn();
    en_i = 1'b0;
    tick(2);
    en_i = 1'b1;
    tick(2);
  endtask

  task automatic model_clear();
    m_cur = '0;
    m_hist = '0;
    m_word = '0;
    m_pend = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    check("rst_cursor", {28'd0, cursor_o}, 32'd0);
    check("rst_disp", {16'd0, disp_word_o}, 32'd0);
    check("rst_word", {16'd0, atk_word_o}, 32'd0);
    check("rst_valid", {31'd0, atk_valid_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_full", {31'd0, full_o}, 32'd0);
    clr_ni = 1'b1;
    tick(2);
    en_i = 1'b1;
    tick(2);

    // 3-cycle glitch must not move the cursor
    mv_raw = 1'b1;
    tick(3);
    mv_raw = 1'b0;
    tick(10);
    check("glitch_cursor", {28'd0, cursor_o}, 32'd0);

    // First high sample at the next edge; cursor lands 6 edges after it
    m_cur = 4'd1;
    push_model(1'b0, 1'b0);
    mv_raw = 1'b1;
    tick(6);
    check("deb_latency_early", {28'd0, cursor_o}, 32'd0);
    tick(1);
    check("deb_latency", {28'd0, cursor_o}, 32'd1);
    tick(3);
    mv_raw = 1'b0;
    tick(10);

    for (int i = 0; i < 15; i++) begin
      m_cur = m_cur + 4'd1;
      push_model(1'b0, 1'b0);
      press(0);
    end
    check("wrap_cursor", {28'd0, cursor_o}, 32'd0);
    push_exp(4'd0, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0);
    press(1);
    push_exp(4'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    press(1);

    // Cell 13, fire held off by atk_ready=0, then accepted
    pick_fire(4'd13);
    tick(5);
    check("held_word", {16'd0, atk_word_o}, 32'h2000);
    accept();
    check("done_hist", {16'd0, disp_word_o}, 32'h2000);
    press(0);
    press(1);
    press(2);
    new_turn();

    push_err();
    press(1);
    check("err_disp", {16'd0, disp_word_o}, 32'h2000);
    push_err();
    press(2);
    check("empty_fire_valid", {31'd0, atk_valid_o}, 32'd0);

    pick_fire(4'd14);
    accept();
    new_turn();
    for (int t = 0; t < 13; t++) begin
      pick_fire(4'(t));
      accept();
      new_turn();
    end
    check("preload_disp", {16'd0, disp_word_o}, 32'h7FFF);
    check("preload_full", {31'd0, full_o}, 32'd0);
    pick_fire(4'd15);
    check("final_word", {16'd0, atk_word_o}, 32'hFFFF);
    accept();
    check("full", {31'd0, full_o}, 32'd1);
    new_turn();
    push_err();
    press(1);
    move_to(4'd0);
    push_err();
    press(1);

    // new_game from PICK, then again mid-HOLD
    model_clear();
    push_model(1'b0, 1'b0);
    new_game_i = 1'b1;
    tick(1);
    new_game_i = 1'b0;
    tick(3);
    pick_fire(4'd2);
    tick(3);
    model_clear();
    push_model(1'b0, 1'b0);
    new_game_i = 1'b1;
    tick(1);
    new_game_i = 1'b0;
    check("ng_valid", {31'd0, atk_valid_o}, 32'd0);
    check("ng_cursor", {28'd0, cursor_o}, 32'd0);
    check("ng_disp", {16'd0, disp_word_o}, 32'd0);
    check("ng_word", {16'd0, atk_word_o}, 32'd0);
    tick(3);

    // Asynchronous clear mid-PICK
    move_to(4'd1);
    m_pend = 16'h0002;
    push_model(1'b0, 1'b0);
    press(1);
    model_clear();
    push_model(1'b0, 1'b0);
    clr_ni = 1'b0;
    #1;
    check("clr_cursor", {28'd0, cursor_o}, 32'd0);
    check("clr_disp", {16'd0, disp_word_o}, 32'd0);
    tick(2);
    clr_ni = 1'b1;
    tick(5);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/attack_entry.md
# attack_entry

Button-driven attack-selection stage for one player board, directly upstream of the slave top-level. Debounces the three raw push-buttons and moves a cursor over the 16-cell grid. Lets the player pick exactly one not-yet-attacked cell, then presents the new cumulative 16-bit attack word to the downstream attack register over a valid/ready handshake. Keeps the attack history, so a committed word always differs from the previous one by exactly one added bit.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples needed before a button level is accepted (5 ms at 100 MHz; benches use 4)
- clk  in  1  system clock, all state on rising edge
- clr_n  in  1  reset; one clock; reset is asynchronous and active-low
- new_game  in  1  synchronous clear of history, pending cell, cursor and FSM
- en  in  1  this player's attack turn, level from game FSM
- btn_move_raw  in  1  raw button: advance cursor
- btn_sel_raw  in  1  raw button: select/deselect cursor cell
- btn_fire_raw  in  1  raw button: commit selection
- atk_ready  in  1  downstream accepts atk_word this cycle
- cursor  out  4  current cell index 0..15
- disp_word  out  16  hist | pending, for LED/7-seg display
- atk_word  out  16  cumulative attack word offered downstream
- atk_valid  out  1  atk_word valid
- err  out  1  one-cycle pulse on illegal select or fire
- full  out  1  all 16 cells attacked (hist == 16'hFFFF)

## Operation
- Reset values: cursor=0, disp_word=0, atk_word=0, atk_valid=0, err=0, full=0, state IDLE, hist=0, pending=0.
- Buttons: two-flop synchronizer, then stability counter, then rising-edge detect. Result is a one-cycle pulse per accepted press. A release also needs DEBOUNCE_CYCLES stable samples. Shorter glitches produce no pulse.
- FSM states: IDLE, PICK, HOLD, DONE.
- IDLE: button pulses ignored. en=1 → PICK.
- PICK, per move pulse: cursor = cursor+1 mod 16 (15 wraps to 0).
- PICK, per sel pulse:
  - hist[cursor]=1 → err pulse, pending unchanged.
  - pending == onehot(cursor) → pending=0 (deselect).
  - Otherwise → pending=onehot(cursor), replacing any earlier pick.
- PICK, per fire pulse:
  - pending==0 → err pulse, stay.
  - Otherwise → atk_word=hist|pending, atk_valid=1, go to HOLD.
- PICK, en=0 → pending=0, go to IDLE.
- Same-cycle pulses in PICK: priority is fire over sel over move. Lower-priority pulses in that cycle are dropped.
- HOLD: atk_valid and atk_word stay stable until atk_valid && atk_ready. On that cycle: hist=atk_word, pending=0, atk_valid=0 next cycle, go to DONE. en falling in HOLD does not retract valid.
- DONE: wait for en=0, then IDLE. One attack per turn.
- Full board (full=1): every sel is err, so fire is impossible.
- new_game (sync) overrides everything except clr_n. It returns all state to reset values in the next cycle, including dropping atk_valid mid-HOLD.
- clr_n low mid-operation: immediate clear, no handshake completion.

## Timing
- Raw rising edge stable from cycle t gives a debounced pulse at cycle t+2+DEBOUNCE_CYCLES: 2 synchronizer cycles, then the counter, then 1 cycle for the registered edge.
- Button pulse to cursor/pending/err update: 1 cycle.
- Fire pulse to atk_valid high: 1 cycle.
- Handshake: acceptance cycle is the cycle with atk_valid && atk_ready; atk_valid low the following cycle. atk_ready while atk_valid=0 is ignored.
- err is exactly one cycle wide per offending pulse.
- disp_word and full are registered-state derived (combinational from hist/pending), no extra latency.

## Structure
- Package battleship_pkg: NCELLS=16, typedef logic [15:0] board_t, enum for FSM state {IDLE, PICK, HOLD, DONE}.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, clr_n, raw, pulse), instantiated three times.
- Top contains FSM, cursor counter, pending/hist registers, output logic.

## Test plan
- DEBOUNCE_CYCLES=4; clr_n low 2 cycles → all outputs 0. Release, en=1, glitch btn_move_raw high for 3 cycles → no cursor change. Hold it 10 cycles → cursor=1 exactly 6 cycles after the first high sample.
- 15 move presses from cursor=1 → cursor wraps to 0. Sel at 0 → disp_word=16'h0001. Sel again → disp_word=0.
- Pick cell 13 and fire with atk_ready=0 for 5 cycles → atk_valid held, atk_word=16'h2000. atk_ready=1 → accepted, atk_valid=0 next cycle, state DONE. Further presses ignored until en cycles 0→1.
- With hist=16'h2000, sel at cell 13 → err pulse, disp_word unchanged. Fire with nothing pending → err pulse, atk_valid stays 0.
- Preload hist to 16'h7FFF via 15 turns, then cell 15 → atk_word=16'hFFFF, full=1. Next turn every sel gives err.
- new_game asserted during HOLD → atk_valid=0, hist=0, cursor=0 next cycle. clr_n pulsed mid-PICK → immediate clear.
